// File: rtl/issue_pkg.sv
// Shared types and fixed latencies for the issue scheduler: functional-unit
// enumeration and a latency lookup used to index the CDB reservation vector.
package issue_pkg;

  typedef enum logic [1:0] {FU_INT, FU_LS, FU_MUL, FU_DIV} fu_e;

  localparam int INT_LAT = 1;
  localparam int LS_LAT  = 1;

  // Multiply/divide latencies are parameters of the top, so they are passed in.
  function automatic int fu_lat(input fu_e fu, input int mul_lat, input int div_lat);
    case (fu)
      FU_INT:  return INT_LAT;
      FU_LS:   return LS_LAT;
      FU_MUL:  return mul_lat;
      default: return div_lat;
    endcase
  endfunction

endpackage

// File: rtl/cdb_res_shreg.sv
// CDB slot-reservation shift register: bit i set means the common data bus is
// already claimed i+1 cycles from now; shifts toward bit 0 each cycle.
module cdb_res_shreg #(
  parameter int W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_shift,
  input  logic                 i_set,
  input  logic [$clog2(W)-1:0] i_set_idx,
  output logic [W-1:0]         o_res
);

  logic [W-1:0] res_q, res_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    res_d = i_shift ? (res_q >> 1) : res_q;
    if (i_set) res_d[i_set_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) res_q <= '0;
    else          res_q <= res_d;
  end

  assign o_res = res_q;

endmodule

// File: rtl/issue_unit.sv
// Single-issue scheduler for int/ls/mul/div queues with CDB slot reservation
// and divider occupancy tracking. Optional counters under `ISSUE_STATS_EN`.
module issue_unit
  import issue_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_int_ready,
  input  logic               i_ls_ready,
  input  logic               i_mul_ready,
  input  logic               i_div_ready,
  input  logic               i_flush,
  output logic               o_int_issue,
  output logic               o_ls_issue,
  output logic               o_mul_issue,
  output logic               o_div_issue,
  output logic               o_div_busy,
  output logic [DIV_LAT-1:0] o_cdb_res
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]        o_issue_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int IDX_W = $clog2(DIV_LAT);
  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam int L_INT = fu_lat(FU_INT, MUL_LAT, DIV_LAT);
  localparam int L_LS  = fu_lat(FU_LS,  MUL_LAT, DIV_LAT);
  localparam int L_MUL = fu_lat(FU_MUL, MUL_LAT, DIV_LAT);
  localparam int L_DIV = fu_lat(FU_DIV, MUL_LAT, DIV_LAT);

  logic [DIV_LAT-1:0] res;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic               rr_q, rr_d;
  logic               int_elig, ls_elig, mul_elig, div_elig;
  logic               gnt_any;
  fu_e                gnt_fu;
  logic               set_en;
  logic [IDX_W-1:0]   set_idx;

  assign int_elig = i_int_ready & ~res[L_INT-1];
  assign ls_elig  = i_ls_ready  & ~res[L_LS-1];
  assign mul_elig = i_mul_ready & ~res[L_MUL-1];
  assign div_elig = i_div_ready & ~res[L_DIV-1] & (div_cnt_q == '0);

  // Fixed priority div > mul > int/ls; rr only moves on a genuine int/ls tie.
  always_comb begin
    gnt_any = 1'b0;
    gnt_fu  = FU_INT;
    rr_d    = rr_q;
    if (!i_flush) begin
      if (div_elig) begin
        gnt_any = 1'b1;
        gnt_fu  = FU_DIV;
      end else if (mul_elig) begin
        gnt_any = 1'b1;
        gnt_fu  = FU_MUL;
      end else if (int_elig && ls_elig) begin
        gnt_any = 1'b1;
        gnt_fu  = rr_q ? FU_LS : FU_INT;
        rr_d    = ~rr_q;
      end else if (int_elig) begin
        gnt_any = 1'b1;
        gnt_fu  = FU_INT;
      end else if (ls_elig) begin
        gnt_any = 1'b1;
        gnt_fu  = FU_LS;
      end
    end
  end

  assign o_int_issue = gnt_any && (gnt_fu == FU_INT);
  assign o_ls_issue  = gnt_any && (gnt_fu == FU_LS);
  assign o_mul_issue = gnt_any && (gnt_fu == FU_MUL);
  assign o_div_issue = gnt_any && (gnt_fu == FU_DIV);

  // Single-cycle ops claim slot t+1, which the shift consumes anyway.
  assign set_en  = o_mul_issue | o_div_issue;
  assign set_idx = o_div_issue ? IDX_W'(L_DIV - 2) : IDX_W'(L_MUL - 2);

  cdb_res_shreg #(.W(DIV_LAT)) u_res (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_shift   (1'b1),
    .i_set     (set_en),
    .i_set_idx (set_idx),
    .o_res     (res)
  );

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (o_div_issue)           div_cnt_d = CNT_W'(DIV_LAT);
    else if (div_cnt_q != '0)  div_cnt_d = div_cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt_q <= '0;
      rr_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      rr_q      <= rr_d;
    end
  end

  assign o_div_busy = (div_cnt_q != '0);
  assign o_cdb_res  = res;

`ifdef ISSUE_STATS_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;
  logic        any_ready;

  assign any_ready = i_int_ready | i_ls_ready | i_mul_ready | i_div_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (gnt_any && (issue_cnt_q != 32'hFFFF_FFFF))
        issue_cnt_q <= issue_cnt_q + 32'd1;
      if (any_ready && !i_flush && !gnt_any && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_issue_cnt = issue_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: a slot-calendar reference model predicts each
// cycle's grants/state; a monitor compares them on the falling edge.
module tb_issue_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_int_ready = 1'b0, i_ls_ready = 1'b0, i_mul_ready = 1'b0, i_div_ready = 1'b0;
  logic i_flush = 1'b0;
  logic o_int_issue, o_ls_issue, o_mul_issue, o_div_issue, o_div_busy;
  logic [DIV_LAT-1:0] o_cdb_res;
`ifdef ISSUE_STATS_EN
  logic [31:0] o_issue_cnt, o_stall_cnt;
`endif

  issue_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_int_ready (i_int_ready),
    .i_ls_ready  (i_ls_ready),
    .i_mul_ready (i_mul_ready),
    .i_div_ready (i_div_ready),
    .i_flush     (i_flush),
    .o_int_issue (o_int_issue),
    .o_ls_issue  (o_ls_issue),
    .o_mul_issue (o_mul_issue),
    .o_div_issue (o_div_issue),
    .o_div_busy  (o_div_busy),
    .o_cdb_res   (o_cdb_res)
`ifdef ISSUE_STATS_EN
    ,
    .o_issue_cnt (o_issue_cnt),
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]         gnt;   // {div, mul, ls, int}
    logic               busy;
    logic [DIV_LAT-1:0] res;
    int unsigned        issue;
    int unsigned        stall;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: absolute-cycle calendar of claimed CDB slots.
  bit          slot[int];
  int          t;
  int          div_free;
  bit          m_rr;
  int unsigned m_issue, m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    slot.delete();
    t        = 0;
    div_free = 0;
    m_rr     = 1'b0;
    m_issue  = 0;
    m_stall  = 0;
  endfunction

  // Drive one cycle (entered at posedge+1), predict, push, advance.
  task automatic step(input bit ir, input bit lr, input bit mr, input bit dr, input bit fl);
    exp_t e;
    bit   ei, el, em, ed;
    int   g;
    i_int_ready = ir; i_ls_ready = lr; i_mul_ready = mr; i_div_ready = dr; i_flush = fl;
    for (int i = 0; i < DIV_LAT; i++) e.res[i] = slot.exists(t + 1 + i);
    e.busy  = (t < div_free);
    e.issue = m_issue;
    e.stall = m_stall;
    ed = dr && !e.busy && !slot.exists(t + DIV_LAT);
    em = mr && !slot.exists(t + MUL_LAT);
    ei = ir && !slot.exists(t + 1);
    el = lr && !slot.exists(t + 1);
    g = -1;
    if (!fl) begin
      if (ed)             g = 3;
      else if (em)        g = 2;
      else if (ei && el) begin g = m_rr ? 1 : 0; m_rr = !m_rr; end
      else if (ei)        g = 0;
      else if (el)        g = 1;
    end
    e.gnt = (g < 0) ? 4'b0000 : 4'(1 << g);
    exp_q.push_back(e);
    case (g)
      0, 1: slot[t + 1] = 1'b1;
      2:    slot[t + MUL_LAT] = 1'b1;
      3:    begin slot[t + DIV_LAT] = 1'b1; div_free = t + 1 + DIV_LAT; end
      default: ;
    endcase
    if (g >= 0) m_issue++;
    else if ((ir || lr || mr || dr) && !fl) m_stall++;
    @(posedge i_clk);
    #1;
    t++;
  endtask

  // Async reset applied mid-cycle; checks outputs before any clock edge.
  task automatic do_reset(input string tag);
    i_int_ready = 1'b0; i_ls_ready = 1'b0; i_mul_ready = 1'b0; i_div_ready = 1'b0; i_flush = 1'b0;
    #1;
    i_rst_n = 1'b0;
    #1;
    check({tag, "_rst_busy"},  64'(o_div_busy), 64'(0));
    check({tag, "_rst_res"},   64'(o_cdb_res), 64'(0));
    check({tag, "_rst_grant"}, 64'({o_div_issue, o_mul_issue, o_ls_issue, o_int_issue}), 64'(0));
`ifdef ISSUE_STATS_EN
    check({tag, "_rst_issue_cnt"}, 64'(o_issue_cnt), 64'(0));
    check({tag, "_rst_stall_cnt"}, 64'(o_stall_cnt), 64'(0));
`endif
    @(negedge i_clk);
    model_reset();
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: compare the head prediction against DUT outputs on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 64'({o_div_issue, o_mul_issue, o_ls_issue, o_int_issue}), 64'(e.gnt));
        check("div_busy", 64'(o_div_busy), 64'(e.busy));
        check("cdb_res", 64'(o_cdb_res), 64'(e.res));
`ifdef ISSUE_STATS_EN
        check("issue_cnt", 64'(o_issue_cnt), 64'(e.issue));
        check("stall_cnt", 64'(o_stall_cnt), 64'(e.stall));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    model_reset();
    do_reset("init");
    step(0, 0, 0, 0, 0);

    // int/ls contention: alternate starting with int.
    do_reset("rr");
    for (int c = 0; c < 8; c++) step(1, 1, 0, 0, 0);

    // mul reservation blocks a later int at the shared slot.
    do_reset("mul_int");
    step(0, 0, 1, 0, 0);
    for (int c = 1; c < 7; c++) step(1, 0, 0, 0, 0);

    // divider occupancy with continuous div demand.
    do_reset("div");
    for (int c = 0; c < 20; c++) step(0, 0, 0, 1, 0);

    // div beats mul, mul follows once its slot is free.
    do_reset("muldiv");
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0);

    // flush suppresses issue while the reservation keeps shifting.
    do_reset("flush");
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // async reset while divider busy and reservations pending.
    do_reset("pre_async");
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset("async");
    step(1, 1, 1, 1, 0);

    // randomized traffic.
    for (int c = 0; c < 1500; c++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
    i_int_ready = 1'b0; i_ls_ready = 1'b0; i_mul_ready = 1'b0; i_div_ready = 1'b0; i_flush = 1'b0;

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge i_clk);
      drain++;
    end
    if (exp_q.size() > 0) check("drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
